// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Serial pattern transmitter. It shifts a programmable PAT_W-bit pattern out
// MSB-first, one bit per clock, for a programmed number of frames. An
// optional idle gap can separate consecutive frames. Typically used to drive
// the serial input of a 10110 sequence detector.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   load_en    load pat_in into the pattern register (IDLE only)
//   pat_in     new pattern value
//   start      begin transmission (IDLE only)
//   repeat_cnt number of frames to send, latched on start
//   gap_len    idle cycles between frames, latched on start
//   abort      abandon the current transmission without a done pulse
//   out_seq    registered serial data bit
//   out_valid  high while out_seq carries a pattern bit
//   busy       high while sending frames or waiting in a gap
//   done       one-cycle pulse after the final bit of the final frame
module seq_pattern_gen #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             out_seq,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   frames_left_q, frames_left_d;
  logic [GAP_W-1:0]   gap_reg_q, gap_reg_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               out_seq_q, out_seq_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Pattern seen by a start; a load in the same cycle takes effect at once.
  logic [PAT_W-1:0]   pat_src;
  logic [IDX_W-1:0]   idx_dec;

  assign pat_src = load_en ? pat_in : pattern_q;
  assign idx_dec = bit_idx_q - IDX_W'(1);

  // bit_idx_q is the index of the bit currently on out_seq, so the next-state
  // logic computes the next output bit directly and every output is a flop.
  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    bit_idx_d     = bit_idx_q;
    frames_left_d = frames_left_q;
    gap_reg_d     = gap_reg_q;
    gap_cnt_d     = gap_cnt_q;
    out_seq_d     = 1'b0;
    out_valid_d   = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_en) begin
          pattern_d = pat_in;
        end
        if (start) begin
          if (repeat_cnt != '0) begin
            frames_left_d = repeat_cnt;
            gap_reg_d     = gap_len;
            bit_idx_d     = LAST_IDX;
            out_seq_d     = pat_src[PAT_W-1];
            out_valid_d   = 1'b1;
            busy_d        = 1'b1;
            state_d       = SEND;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      SEND: begin
        if (abort) begin
          bit_idx_d     = '0;
          frames_left_d = '0;
          gap_reg_d     = '0;
          gap_cnt_d     = '0;
          state_d       = IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d   = idx_dec;
          out_seq_d   = pattern_q[idx_dec];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          // Last bit of a frame is on the line now.
          frames_left_d = frames_left_q - CNT_W'(1);
          if (frames_left_q == CNT_W'(1)) begin
            gap_reg_d = '0;
            done_d    = 1'b1;
            state_d   = DONE;
          end else if (gap_reg_q == '0) begin
            bit_idx_d   = LAST_IDX;
            out_seq_d   = pattern_q[PAT_W-1];
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            gap_cnt_d = gap_reg_q;
            busy_d    = 1'b1;
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        // gap_cnt_q counts the gap cycles still to show, including this one.
        if (abort) begin
          bit_idx_d     = '0;
          frames_left_d = '0;
          gap_reg_d     = '0;
          gap_cnt_d     = '0;
          state_d       = IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d   = '0;
          bit_idx_d   = LAST_IDX;
          out_seq_d   = pattern_q[PAT_W-1];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          busy_d    = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset restores the default pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pattern_q     <= PATTERN;
      bit_idx_q     <= '0;
      frames_left_q <= '0;
      gap_reg_q     <= '0;
      gap_cnt_q     <= '0;
      out_seq_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      bit_idx_q     <= bit_idx_d;
      frames_left_q <= frames_left_d;
      gap_reg_q     <= gap_reg_d;
      gap_cnt_q     <= gap_cnt_d;
      out_seq_q     <= out_seq_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign out_seq   = out_seq_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter; the transmit-side counterpart of the Mealy 10110 overlapping sequence detector.
- Shifts a programmable PAT_W-bit pattern out MSB-first, one bit per clock, for a programmed number of frames.
- An optional idle gap can be inserted between frames.
- Drives the detector's serial input in system-level loopback and in detector benches.

Parameters:
- PAT_W, 5, pattern length in bits (legal range 2..16).
- PATTERN, 5'b10110, pattern register reset value.
- CNT_W, 8, width of the frame-repeat counter.
- GAP_W, 4, width of the inter-frame gap length.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- load_en  input  1  load pat_in into the pattern register; honoured in IDLE only.
- pat_in  input  PAT_W  new pattern value.
- start  input  1  begin transmission; honoured in IDLE only.
- repeat_cnt  input  CNT_W  number of frames to send; latched on start.
- gap_len  input  GAP_W  idle cycles between frames; latched on start.
- abort  input  1  synchronous abort of the current transmission.
- out_seq  output  1  serial data bit, registered.
- out_valid  output  1  high while out_seq carries a pattern bit.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse after the final bit of the final frame.

Behaviour:
- Reset state:
  - state=IDLE; pattern register=PATTERN.
  - out_seq=0, out_valid=0, busy=0, done=0; all counters 0.
- All outputs are registered. Nothing combinational from inputs to outputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - load_en=1: pattern register <= pat_in.
  - start=1 and repeat_cnt!=0: latch repeat_cnt into frames_left and gap_len into gap_reg; bit_idx=PAT_W-1; go to SEND.
  - Latency: the first bit (pattern MSB) is on out_seq, with out_valid=1, in the cycle after the start edge.
  - start=1 and repeat_cnt=0: go directly to DONE. No bits sent; done pulses in the next cycle.
  - load_en and start in the same cycle: the load applies and the transmission uses the new pat_in value.
- SEND:
  - Each cycle: out_seq=pattern[bit_idx], out_valid=1, busy=1; bit_idx decrements.
  - A frame is exactly PAT_W consecutive valid cycles.
  - After the last bit (bit_idx=0), frames_left decrements:
    - frames_left was 1: go to DONE.
    - Otherwise, gap_reg=0: reload bit_idx=PAT_W-1 and stay in SEND. Frames are back-to-back with no bubble, e.g. 1011010110.
    - Otherwise, gap_reg>0: go to GAP.
- GAP:
  - out_seq=0, out_valid=0, busy=1 for exactly gap_reg cycles.
  - Then go to SEND with bit_idx=PAT_W-1.
- DONE:
  - done=1 and busy=0 for exactly one cycle; out_seq=0, out_valid=0.
  - Next state is IDLE. start is ignored in this cycle.
- Ignored inputs:
  - start and load_en are ignored outside IDLE.
  - pat_in, repeat_cnt and gap_len changes mid-transmission have no effect.
- abort:
  - In SEND or GAP: next state is IDLE; out_valid=0, out_seq=0, busy=0. No done pulse; counters cleared.
  - In IDLE or DONE: no effect (DONE still pulses done).
- Priority (highest first): rst > abort > start/load_en.
- Reset mid-transmission: the pattern register reverts to PATTERN. Any loaded pattern is lost.
- Counter behaviour: bit_idx spans 0..PAT_W-1. frames_left never underflows; a repeat_cnt of 2^CNT_W-1 is legal.

Test Plan:
- Reset, then start with repeat_cnt=1, gap_len=0 (default pattern) -> out_seq 1,0,1,1,0 with out_valid=1 in cycles 1-5 after the start edge; done=1 in cycle 6; busy=1 in cycles 1-5 only.
- repeat_cnt=3, gap_len=0 -> 15 contiguous valid bits 101101011010110. With out_seq looped to the 10110 detector, det_out asserts exactly 3 times, on the final bit of each frame. done pulses once.
- load_en with pat_in=5'b11001 in IDLE, then start with repeat_cnt=2, gap_len=2 -> 11001, two cycles with out_valid=0 and out_seq=0, 11001, then done. Detector loopback gives det_out=0 throughout.
- start with repeat_cnt=0 -> no valid cycles; done=1 exactly one cycle after the start edge; busy stays 0.
- Mid-frame checks with repeat_cnt=4:
  - abort after the 3rd bit of frame 2 -> next cycle out_valid=0, busy=0, no done pulse; a later start is honoured normally.
  - Repeating with rst=1 instead of abort -> all outputs 0 and pattern register = 10110.
- Ignored inputs: start and load_en pulsed while busy -> no restart and no pattern change; the transmission completes with the original frame count.
